mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified line-wide memory port between the I-cache fill path and the D-cache fill/write path
//  of the pipelined CPU. Grants one transaction at a time, latches its command, and routes the completion
//  pulse back to the owner. Round-robin between requesters prevents fetch or data starvation.
//  Sits between cpu (i_*/d_* memory side) and a single-ported Memory instance.
// PARAMETERS
//  WORD_SIZE   16  data/address word width
//  LINE_WORDS  4   words per cache line; read data width = LINE_WORDS*WORD_SIZE
//  CNT_W       16  width of saturating performance counters
// PORTS
//  clk            in   1            clock, all state on rising edge
//  reset_n        in   1            synchronous, active-low reset
//  i_readM        in   1            I-side line read request; level, held until i_readyM
//  i_address      in   WORD_SIZE    I-side line address (word address, low 2 bits ignored by memory)
//  i_data         out  LINE*WORD    I-side read line; valid only while i_readyM=1
//  i_readyM       out  1            1-cycle pulse: I read complete
//  d_readM        in   1            D-side line read request; level, held until d_readyM
//  d_writeM       in   1            D-side single-word write request; level, held until d_doneM
//  d_address      in   WORD_SIZE    D-side address
//  d_wdata        in   WORD_SIZE    D-side write word, sampled at grant
//  d_data         out  LINE*WORD    D-side read line; valid only while d_readyM=1
//  d_readyM       out  1            1-cycle pulse: D read complete
//  d_doneM        out  1            1-cycle pulse: D write complete
//  m_readM        out  1            memory read command, held for whole transaction
//  m_writeM       out  1            memory write command, held for whole transaction
//  m_address      out  WORD_SIZE    latched address of granted transaction
//  m_wdata        out  WORD_SIZE    latched write word
//  m_data         in   LINE*WORD    memory read line, valid with m_readyM
//  m_readyM       in   1            memory read-complete pulse
//  m_doneM        in   1            memory write-complete pulse
//  num_conflict   out  CNT_W        cycles a request waited while the other side owned the port (saturating)
// BEHAVIOUR
//  Reset: state=IDLE; m_readM=m_writeM=0; m_address=m_wdata=0; i_readyM=d_readyM=d_doneM=0;
//   num_conflict=0; last_grant=I (so D wins first contention). Reset mid-transaction aborts it; no pulse
//   is emitted; Memory shares reset_n.
//  States: IDLE, I_RD, D_RD, D_WR.
//  IDLE: if no request stay. If one side requests, grant it. If both, grant the side != last_grant.
//   D side with d_writeM=1 -> D_WR (d_writeM wins if both d_readM and d_writeM set; protocol error, not
//   flagged). Grant latches address/wdata, sets m_readM or m_writeM from next cycle, updates last_grant.
//  I_RD/D_RD: hold m_readM and latched address. On m_readyM: forward pulse to owner ready, route m_data
//   to owner data (combinational pass-through same cycle), next state IDLE, m_readM=0 next cycle.
//  D_WR: hold m_writeM/m_wdata; on m_doneM pulse d_doneM same cycle, next state IDLE.
//  Completion pulses never go to the non-owner; stray m_readyM/m_doneM in IDLE or wrong state ignored.
//  Latency: request seen in cycle N -> m_readM/m_writeM high in N+1. Turnaround after completion is one
//   IDLE cycle minimum; a pending request is granted in that IDLE cycle.
//  Requester dropping its request mid-transaction: transaction still completes, pulse still issued.
//  Non-owner data outputs drive 0.
//  num_conflict: +1 each cycle state!=IDLE and the non-owner request is high, or state==IDLE and both
//   sides request (loser waits); saturates at all-ones.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/I_RD/D_RD/D_WR), owner enum (OWN_I, OWN_D).
//  No sub-module required; optional arb_rr2 (2-way round-robin pick) if reused elsewhere.
// TESTING
//  1. Only i_readM at addr 0x0010, memory returns m_readyM after 4 cycles -> m_readM 1 for 4 cycles,
//     m_address=0x0010, single i_readyM pulse with i_data=m_data, d_* outputs stay 0.
//  2. i_readM and d_readM raised same cycle after reset -> D granted first (m_address=d_address),
//     I granted in IDLE cycle after d_readyM; num_conflict counts every I wait cycle.
//  3. Back-to-back contention, 3 transactions each side -> grants alternate D,I,D,I,D,I.
//  4. d_writeM addr 0x0020 data 0xBEEF -> m_writeM=1, m_wdata=0xBEEF until m_doneM; one d_doneM pulse;
//     d_wdata changed after grant does not alter m_wdata.
//  5. reset_n low for 1 cycle in mid D_RD -> next cycle all outputs at reset values, no d_readyM pulse;
//     late m_readyM in IDLE ignored.
//  6. Force num_conflict to near all-ones via long I transaction with D waiting -> holds 0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and port-owner identity.
package mem_port_arbiter_pkg;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_CNT_W      = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_I_RD = 2'd1;
    localparam logic [1:0] ST_D_RD = 2'd2;
    localparam logic [1:0] ST_D_WR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        I_RD = ST_I_RD,
        D_RD = ST_D_RD,
        D_WR = ST_D_WR
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic owner_t other_side(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins; on contention the side that did not win last time wins.
module mem_port_arbiter_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_t last_grant_i,
    output logic   valid_o,
    output owner_t grant_o
);

    always_comb begin
        valid_o = i_req_i | d_req_i;
        grant_o = OWN_I;
        if (i_req_i && d_req_i) begin
            grant_o = other_side(last_grant_i);
        end else if (d_req_i) begin
            grant_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache fill path and the D-cache fill/write path.
// One transaction in flight at a time; the completion pulse and read line are routed back to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_readM,
    input  logic [WORD_SIZE-1:0]            i_address,
    output logic [LINE_WORDS*WORD_SIZE-1:0] i_data,
    output logic                            i_readyM,
    input  logic                            d_readM,
    input  logic                            d_writeM,
    input  logic [WORD_SIZE-1:0]            d_address,
    input  logic [WORD_SIZE-1:0]            d_wdata,
    output logic [LINE_WORDS*WORD_SIZE-1:0] d_data,
    output logic                            d_readyM,
    output logic                            d_doneM,
    output logic                            m_readM,
    output logic                            m_writeM,
    output logic [WORD_SIZE-1:0]            m_address,
    output logic [WORD_SIZE-1:0]            m_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] m_data,
    input  logic                            m_readyM,
    input  logic                            m_doneM,
    output logic [CNT_W-1:0]                num_conflict
);

    state_t                state_q, state_d;
    owner_t                last_grant_q, last_grant_d;
    logic                  m_read_q, m_read_d;
    logic                  m_write_q, m_write_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]      conflict_q, conflict_d;

    logic                  d_req;
    logic                  arb_valid;
    owner_t                arb_grant;
    logic                  wait_cycle;

    assign d_req = d_readM | d_writeM;

    mem_port_arbiter_arb_rr2 u_arb (
        .i_req_i      (i_readM),
        .d_req_i      (d_req),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .grant_o      (arb_grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_read_d     = m_read_q;
        m_write_d    = m_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    last_grant_d = arb_grant;
                    if (arb_grant == OWN_D) begin
                        addr_d = d_address;
                        // A write outranks a simultaneous read request from the same side.
                        if (d_writeM) begin
                            state_d   = D_WR;
                            m_write_d = 1'b1;
                            wdata_d   = d_wdata;
                        end else begin
                            state_d  = D_RD;
                            m_read_d = 1'b1;
                        end
                    end else begin
                        addr_d   = i_address;
                        state_d  = I_RD;
                        m_read_d = 1'b1;
                    end
                end
            end
            I_RD, D_RD: begin
                if (m_readyM) begin
                    state_d  = IDLE;
                    m_read_d = 1'b0;
                end
            end
            D_WR: begin
                if (m_doneM) begin
                    state_d   = IDLE;
                    m_write_d = 1'b0;
                end
            end
        endcase
    end

    // A cycle is a conflict whenever some request is held back by the other side.
    always_comb begin
        wait_cycle = 1'b0;
        unique case (state_q)
            IDLE:       wait_cycle = i_readM & d_req;
            I_RD:       wait_cycle = d_req;
            D_RD, D_WR: wait_cycle = i_readM;
        endcase
        conflict_d = conflict_q;
        if (wait_cycle && (conflict_q != '1)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            conflict_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            conflict_q   <= conflict_d;
        end
    end

    // Completion is pass-through; gating with reset_n keeps an aborted transaction silent.
    assign i_readyM = reset_n & (state_q == I_RD) & m_readyM;
    assign d_readyM = reset_n & (state_q == D_RD) & m_readyM;
    assign d_doneM  = reset_n & (state_q == D_WR) & m_doneM;

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
        assign i_data[gi*WORD_SIZE +: WORD_SIZE] = i_readyM ? m_data[gi*WORD_SIZE +: WORD_SIZE] : '0;
        assign d_data[gi*WORD_SIZE +: WORD_SIZE] = d_readyM ? m_data[gi*WORD_SIZE +: WORD_SIZE] : '0;
    end

    assign m_readM      = m_read_q;
    assign m_writeM     = m_write_q;
    assign m_address    = addr_q;
    assign m_wdata      = wdata_q;
    assign num_conflict = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked cycle-by-cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int WS = 16;
    localparam int LW = 4;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic i_readM, d_readM, d_writeM, m_readyM, m_doneM;
    logic [WS-1:0] i_address, d_address, d_wdata;
    logic [LW*WS-1:0] m_data;
    logic [LW*WS-1:0] i_data, d_data;
    logic i_readyM, d_readyM, d_doneM, m_readM, m_writeM;
    logic [WS-1:0] m_address, m_wdata;
    logic [CW-1:0] num_conflict;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(WS), .LINE_WORDS(LW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_readyM(i_readyM),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
        .d_data(d_data), .d_readyM(d_readyM), .d_doneM(d_doneM),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
        .m_data(m_data), .m_readyM(m_readyM), .m_doneM(m_doneM), .num_conflict(num_conflict)
    );

    // Transaction-level reference: who holds the port, what was latched, who won last.
    bit busy, own, is_wr, last, done_i, done_d;
    logic [WS-1:0] mdl_addr, mdl_wdata;
    int cnt, age, lat, lat_force;
    int n_pass = 0, n_checks = 0, cyc = 0;

    logic obs_m_read, obs_m_write, obs_i_rdy, obs_d_rdy, obs_d_done;
    logic [WS-1:0] obs_addr, obs_wdata;
    logic [CW-1:0] obs_cnt;

    bit ihold, dhold, dwr, dboth;
    logic [WS-1:0] grants[$];
    int gcyc[$];
    logic [WS-1:0] exp3 [6];
    int nrd, npulse, nother, dp_cyc, ki, kd;
    bit prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic model_edge();
        bit ireq, dreq, win;
        done_i = 0;
        done_d = 0;
        if (!reset_n) begin
            busy = 0; own = 0; is_wr = 0; last = 0; cnt = 0; age = 0;
            mdl_addr = '0; mdl_wdata = '0;
            return;
        end
        ireq = i_readM;
        dreq = d_readM || d_writeM;
        if (busy ? (own ? ireq : dreq) : (ireq && dreq))
            cnt = (cnt == CNT_MAX) ? cnt : cnt + 1;
        if (busy) begin
            if (is_wr ? m_doneM : m_readyM) begin
                busy = 0;
                if (own) done_d = 1; else done_i = 1;
            end else begin
                age++;
            end
        end else if (ireq || dreq) begin
            win = (ireq && dreq) ? !last : dreq;
            busy = 1; own = win; last = win; age = 1;
            if (win) begin
                mdl_addr = d_address;
                is_wr = d_writeM;
                if (d_writeM) mdl_wdata = d_wdata;
            end else begin
                mdl_addr = i_address;
                is_wr = 0;
            end
        end
    endtask

    task automatic tick();
        bit ei, ed, edn;
        @(negedge clk);
        cyc++;
        ei  = reset_n && busy && !own && m_readyM;
        ed  = reset_n && busy && own && !is_wr && m_readyM;
        edn = reset_n && busy && own && is_wr && m_doneM;
        obs_m_read = m_readM; obs_m_write = m_writeM; obs_addr = m_address; obs_wdata = m_wdata;
        obs_i_rdy = i_readyM; obs_d_rdy = d_readyM; obs_d_done = d_doneM; obs_cnt = num_conflict;
        check("m_readM", 64'(m_readM), 64'(busy && !is_wr));
        check("m_writeM", 64'(m_writeM), 64'(busy && is_wr));
        check("m_address", 64'(m_address), 64'(mdl_addr));
        check("m_wdata", 64'(m_wdata), 64'(mdl_wdata));
        check("i_readyM", 64'(i_readyM), 64'(ei));
        check("d_readyM", 64'(d_readyM), 64'(ed));
        check("d_doneM", 64'(d_doneM), 64'(edn));
        check("i_data", i_data, ei ? m_data : 64'd0);
        check("d_data", d_data, ed ? m_data : 64'd0);
        check("num_conflict", 64'(num_conflict), 64'(cnt));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_mem(input bit stray);
        m_data = {$urandom, $urandom};
        if (busy && age == 1) lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 5));
        m_readyM = busy && !is_wr && age == lat;
        m_doneM  = busy && is_wr && age == lat;
        if (stray && !(busy && !is_wr) && $urandom_range(0, 9) == 0) m_readyM = 1'b1;
        if (stray && !(busy && is_wr) && $urandom_range(0, 9) == 0) m_doneM = 1'b1;
    endtask

    task automatic drive_reqs();
        if (done_i) ihold = 0;
        if (done_d) dhold = 0;
        if (ihold && busy && !own && $urandom_range(0, 15) == 0) ihold = 0;
        if (dhold && busy && own && $urandom_range(0, 15) == 0) dhold = 0;
        if (busy && own && is_wr) d_wdata = 16'($urandom);
        if (!ihold && $urandom_range(0, 2) == 0) begin
            ihold = 1; i_address = 16'($urandom);
        end
        if (!dhold && $urandom_range(0, 2) == 0) begin
            dhold = 1; dwr = ($urandom_range(0, 2) == 0); dboth = ($urandom_range(0, 4) == 0);
            d_address = 16'($urandom); d_wdata = 16'($urandom);
        end
        i_readM  = ihold;
        d_writeM = dhold && dwr;
        d_readM  = dhold && (!dwr || dboth);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_readM = 0; d_readM = 0; d_writeM = 0; m_readyM = 0; m_doneM = 0;
        tick();
        reset_n = 1'b1;
        ihold = 0; dhold = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        i_readM = 0; d_readM = 0; d_writeM = 0; m_readyM = 0; m_doneM = 0;
        i_address = '0; d_address = '0; d_wdata = '0; m_data = '0;
        lat = 1; lat_force = 0;
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        reset_n = 1'b1;

        // Reset values, then a lone I read with a 4-cycle memory.
        tick();
        check("reset_m_readM", 64'(obs_m_read), 64'd0);
        check("reset_cnt", 64'(obs_cnt), 64'd0);
        lat_force = 4; i_address = 16'h0010; i_readM = 1; drive_mem(0);
        nrd = 0; npulse = 0; nother = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs_m_read) begin
                nrd++;
                check("t1_addr", 64'(obs_addr), 64'h0010);
            end
            if (obs_i_rdy) npulse++;
            if (obs_d_rdy || obs_d_done) nother++;
            if (done_i) i_readM = 0;
            drive_mem(0);
        end
        check("t1_read_cycles", 64'(nrd), 64'd4);
        check("t1_i_pulses", 64'(npulse), 64'd1);
        check("t1_d_pulses", 64'(nother), 64'd0);

        // Simultaneous requests after reset: D first, I in the IDLE cycle after d_readyM.
        do_reset();
        i_address = 16'h0100; d_address = 16'h0200; i_readM = 1; d_readM = 1; lat_force = 3;
        drive_mem(0);
        grants.delete(); gcyc.delete(); prev = 0; dp_cyc = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (obs_m_read && !prev) begin grants.push_back(obs_addr); gcyc.push_back(cyc); end
            prev = obs_m_read;
            if (obs_d_rdy) dp_cyc = cyc;
            if (done_i) i_readM = 0;
            if (done_d) d_readM = 0;
            drive_mem(0);
        end
        check("t2_ngrants", 64'(grants.size()), 64'd2);
        check("t2_first_D", 64'(grants[0]), 64'h0200);
        check("t2_then_I", 64'(grants[1]), 64'h0100);
        check("t2_turnaround", 64'(gcyc[1] - dp_cyc), 64'd2);
        check("t2_conflicts", 64'(obs_cnt), 64'd4);

        // Back-to-back contention: grants alternate D,I,D,I,D,I.
        do_reset();
        ki = 0; kd = 0; i_address = 16'h0300; d_address = 16'h0400;
        i_readM = 1; d_readM = 1; lat_force = 2; drive_mem(0);
        grants.delete(); prev = 0;
        exp3 = '{16'h0400, 16'h0300, 16'h0401, 16'h0301, 16'h0402, 16'h0302};
        for (int k = 0; k < 40; k++) begin
            tick();
            if (obs_m_read && !prev) grants.push_back(obs_addr);
            prev = obs_m_read;
            if (done_i) begin ki++; if (ki < 3) i_address = 16'h0300 + 16'(ki); else i_readM = 0; end
            if (done_d) begin kd++; if (kd < 3) d_address = 16'h0400 + 16'(kd); else d_readM = 0; end
            drive_mem(0);
        end
        check("t3_ngrants", 64'(grants.size()), 64'd6);
        for (int g = 0; g < 6; g++) check($sformatf("t3_grant%0d", g), 64'(grants[g]), 64'(exp3[g]));

        // Single-word write; d_wdata changing after grant must not leak into m_wdata.
        d_address = 16'h0020; d_wdata = 16'hBEEF; d_writeM = 1; lat_force = 3; drive_mem(0);
        nrd = 0; npulse = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (obs_m_write) begin
                nrd++;
                check("t4_wdata", 64'(obs_wdata), 64'hBEEF);
                check("t4_addr", 64'(obs_addr), 64'h0020);
            end
            if (obs_d_done) npulse++;
            if (done_d) d_writeM = 0;
            d_wdata = 16'h1234 + 16'(k);
            drive_mem(0);
        end
        check("t4_write_cycles", 64'(nrd), 64'd3);
        check("t4_done_pulses", 64'(npulse), 64'd1);

        // Reset in the middle of a D read aborts it; a late m_readyM is ignored.
        d_address = 16'h0030; d_readM = 1; lat_force = 10; drive_mem(0);
        repeat (3) begin tick(); drive_mem(0); end
        reset_n = 0; d_readM = 0; drive_mem(0);
        tick();
        reset_n = 1; drive_mem(0); m_readyM = 1;
        tick();
        check("t5_no_d_ready", 64'(obs_d_rdy), 64'd0);
        check("t5_m_readM", 64'(obs_m_read), 64'd0);
        check("t5_m_address", 64'(obs_addr), 64'd0);
        check("t5_cnt", 64'(obs_cnt), 64'd0);
        m_readyM = 0;

        // Long I transaction with D waiting drives the counter into saturation.
        do_reset();
        i_address = 16'h0600; i_readM = 1; lat_force = 300; drive_mem(0);
        tick();
        d_address = 16'h0700; d_readM = 1; drive_mem(0);
        repeat (290) begin tick(); drive_mem(0); end
        check("t6_saturated", 64'(obs_cnt), 64'(CNT_MAX));
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_i) i_readM = 0;
            if (done_d) d_readM = 0;
            drive_mem(0);
        end
        check("t6_held", 64'(obs_cnt), 64'(CNT_MAX));

        // Randomized traffic with stray completion pulses and mid-transaction request drops.
        do_reset();
        lat_force = 0;
        for (int k = 0; k < 3000; k++) begin
            drive_reqs();
            drive_mem(1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
